// File: rtl/mem_stall_bridge.sv
// mem_stall_bridge
// Bridges the multicycle CPU control path to an Avalon-MM memory bus. One
// load or store is serviced at a time; while it is outstanding, `stall`
// holds the control decoder in place. The bridge selects byte/halfword
// lanes, sign/zero-extends loads and rejects misaligned accesses without
// touching the bus.
//
// Optional feature macro: MEM_STALL_BRIDGE_TIMEOUT_EN
//   When defined, a transaction that spends MAX_WAIT cycles in CMD/RDWAIT
//   is abandoned and completes with rsp_err=1.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cpu_rd, cpu_wr      CPU load/store request, held until stall drops
//   cpu_addr            byte address
//   cpu_size            00 byte, 01 half, 10/11 word
//   cpu_signed          sign-extend byte/half loads
//   cpu_wdata           right-aligned store data
//   stall               CPU must hold its state and request
//   cpu_rdata           aligned, extended load result (held between loads)
//   rsp_valid, rsp_err  one-cycle completion pulse and its error flag
//   avm_*               Avalon-MM master signals
module mem_stall_bridge #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_signed,
  input  logic [31:0]       cpu_wdata,
  output logic              stall,
  output logic [31:0]       cpu_rdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CMD    = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]  state;
  logic [1:0]  addr_lo;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        is_rd;
  logic        err_q;
  logic        req;
  logic        misaligned;
  logic [3:0]  be_nxt;
  logic [31:0] wd_nxt;
  logic [31:0] shifted;
  logic [31:0] rd_ext;
  logic        timeout_hit;

  assign req = cpu_rd | cpu_wr;

  // size 11 behaves as a word, so bit 1 alone marks a word access
  assign misaligned = ((cpu_size == 2'b01) && cpu_addr[0]) ||
                      (cpu_size[1] && (cpu_addr[1:0] != 2'b00));

  // Combinational so the decoder sees the hold in the same cycle the
  // request first appears.
  assign stall = ((state == S_IDLE) && req) || (state == S_CMD) || (state == S_RDWAIT);

  assign avm_read  = (state == S_CMD) && is_rd;
  assign avm_write = (state == S_CMD) && !is_rd;
  assign rsp_valid = (state == S_DONE);
  assign rsp_err   = (state == S_DONE) && err_q;

  // Lane enables and replicated store data for the incoming request.
  always_comb begin
    be_nxt = 4'b1111;
    wd_nxt = cpu_wdata;
    if (!cpu_size[1]) begin
      if (cpu_size[0]) begin
        be_nxt = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wd_nxt = {2{cpu_wdata[15:0]}};
      end else begin
        be_nxt = 4'b0001 << cpu_addr[1:0];
        wd_nxt = {4{cpu_wdata[7:0]}};
      end
    end
  end

  // Bring the addressed lane down to bit 0, then extend per the latched
  // size/signedness. Word accesses are aligned, so their shift is zero.
  always_comb begin
    shifted = avm_readdata >> {addr_lo, 3'b000};
    rd_ext  = shifted;
    if (!size_q[1]) begin
      if (size_q[0]) begin
        rd_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      end else begin
        rd_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      end
    end
  end

`ifdef MEM_STALL_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts cycles spent in CMD/RDWAIT. CMD is only entered from IDLE, so
  // holding the count at zero in IDLE clears it on every CMD entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_IDLE) begin
      wait_cnt <= '0;
    end else if ((state == S_CMD) || (state == S_RDWAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // True during the MAX_WAIT-th waiting cycle.
  assign timeout_hit = (wait_cnt == CNT_W'(MAX_WAIT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Transaction FSM plus request latching and load capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      addr_lo        <= 2'b00;
      size_q         <= 2'b00;
      signed_q       <= 1'b0;
      is_rd          <= 1'b0;
      err_q          <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      cpu_rdata      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            avm_address    <= {cpu_addr[ADDR_W-1:2], 2'b00};
            addr_lo        <= cpu_addr[1:0];
            size_q         <= cpu_size;
            signed_q       <= cpu_signed;
            is_rd          <= cpu_rd;
            avm_writedata  <= wd_nxt;
            avm_byteenable <= be_nxt;
            err_q          <= misaligned;
            state          <= misaligned ? S_DONE : S_CMD;
          end
        end
        S_CMD: begin
          // A real completion wins over a timeout in the same cycle; an
          // accepted read only moves to RDWAIT when time remains.
          if (!avm_waitrequest && !is_rd) begin
            state <= S_DONE;
          end else if (!avm_waitrequest && avm_readdatavalid) begin
            cpu_rdata <= rd_ext;
            state     <= S_DONE;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (!avm_waitrequest) begin
            state <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          if (avm_readdatavalid) begin
            cpu_rdata <= rd_ext;
            state     <= S_DONE;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stall_bridge.sv
// tb_mem_stall_bridge
// Directed testbench for mem_stall_bridge. Each scenario task drives the
// CPU and bus sides cycle by cycle and compares outputs against
// hand-computed values. Inputs change 2 time units after a rising edge and
// outputs are compared 1 unit later, well clear of the next edge.
module tb_mem_stall_bridge;

`ifdef MEM_STALL_BRIDGE_TIMEOUT_EN
  localparam int MW = 8;
`else
  localparam int MW = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_size;
  logic        cpu_signed;
  logic [31:0] cpu_wdata;
  logic        stall;
  logic [31:0] cpu_rdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_rdata;

  mem_stall_bridge #(.ADDR_W(32), .MAX_WAIT(MW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cpu_rd            (cpu_rd),
    .cpu_wr            (cpu_wr),
    .cpu_addr          (cpu_addr),
    .cpu_size          (cpu_size),
    .cpu_signed        (cpu_signed),
    .cpu_wdata         (cpu_wdata),
    .stall             (stall),
    .cpu_rdata         (cpu_rdata),
    .rsp_valid         (rsp_valid),
    .rsp_err           (rsp_err),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  // Advance one cycle and land 2 units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drop_request();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drop_request();
    cpu_addr = '0; cpu_size = 2'b00; cpu_signed = 1'b0; cpu_wdata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    #1;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_stall got=%b exp=0", stall); end
    vec_cnt++; if ({avm_read, avm_write} !== 2'b00) begin err_cnt++; $display("[TB] FAIL rst_strobes got=%b exp=00", {avm_read, avm_write}); end
    vec_cnt++; if ({rsp_valid, rsp_err} !== 2'b00) begin err_cnt++; $display("[TB] FAIL rst_rsp got=%b exp=00", {rsp_valid, rsp_err}); end
    vec_cnt++; if ({avm_address, avm_writedata, avm_byteenable} !== 68'h0) begin err_cnt++; $display("[TB] FAIL rst_bus got=%h/%h/%b exp=0", avm_address, avm_writedata, avm_byteenable); end
    vec_cnt++; if (cpu_rdata !== 32'h0) begin err_cnt++; $display("[TB] FAIL rst_rdata got=%h exp=0", cpu_rdata); end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_word_write();
    cpu_wr = 1'b1; cpu_addr = 32'h100; cpu_size = 2'b10; cpu_wdata = 32'hDEADBEEF;
    #1;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("[TB] FAIL ww_stall_req got=%b exp=1", stall); end
    vec_cnt++; if (avm_write !== 1'b0) begin err_cnt++; $display("[TB] FAIL ww_write_early got=%b exp=0", avm_write); end
    step();
    vec_cnt++; if ({avm_write, avm_read} !== 2'b10) begin err_cnt++; $display("[TB] FAIL ww_cmd_strobes got=%b exp=10", {avm_write, avm_read}); end
    vec_cnt++; if (avm_address !== 32'h100) begin err_cnt++; $display("[TB] FAIL ww_addr got=%h exp=00000100", avm_address); end
    vec_cnt++; if (avm_byteenable !== 4'b1111) begin err_cnt++; $display("[TB] FAIL ww_be got=%b exp=1111", avm_byteenable); end
    vec_cnt++; if (avm_writedata !== 32'hDEADBEEF) begin err_cnt++; $display("[TB] FAIL ww_wdata got=%h exp=deadbeef", avm_writedata); end
    vec_cnt++; if ({stall, rsp_valid} !== 2'b10) begin err_cnt++; $display("[TB] FAIL ww_cmd_stall got=%b exp=10", {stall, rsp_valid}); end
    step();
    vec_cnt++; if ({stall, rsp_valid, rsp_err, avm_write} !== 4'b0100) begin err_cnt++; $display("[TB] FAIL ww_done got=%b exp=0100", {stall, rsp_valid, rsp_err, avm_write}); end
    drop_request();
    step();
    vec_cnt++; if ({stall, rsp_valid} !== 2'b00) begin err_cnt++; $display("[TB] FAIL ww_idle got=%b exp=00", {stall, rsp_valid}); end
  endtask

  task automatic test_signed_byte_read();
    cpu_rd = 1'b1; cpu_addr = 32'h203; cpu_size = 2'b00; cpu_signed = 1'b1;
    #1;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("[TB] FAIL sb_stall_req got=%b exp=1", stall); end
    step();
    vec_cnt++; if (avm_read !== 1'b1) begin err_cnt++; $display("[TB] FAIL sb_read got=%b exp=1", avm_read); end
    vec_cnt++; if (avm_address !== 32'h200) begin err_cnt++; $display("[TB] FAIL sb_addr got=%h exp=00000200", avm_address); end
    vec_cnt++; if (avm_byteenable !== 4'b1000) begin err_cnt++; $display("[TB] FAIL sb_be got=%b exp=1000", avm_byteenable); end
    step();
    vec_cnt++; if ({avm_read, stall} !== 2'b01) begin err_cnt++; $display("[TB] FAIL sb_rdwait got=%b exp=01", {avm_read, stall}); end
    step();
    step();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h80FFFFFF;
    #1;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("[TB] FAIL sb_stall_rdv got=%b exp=1", stall); end
    step();
    avm_readdatavalid = 1'b0; avm_readdata = '0;
    exp_rdata = 32'hFFFFFF80;
    #1;
    vec_cnt++; if (cpu_rdata !== exp_rdata) begin err_cnt++; $display("[TB] FAIL sb_rdata got=%h exp=%h", cpu_rdata, exp_rdata); end
    vec_cnt++; if ({stall, rsp_valid, rsp_err} !== 3'b010) begin err_cnt++; $display("[TB] FAIL sb_done got=%b exp=010", {stall, rsp_valid, rsp_err}); end
    drop_request();
    step();
  endtask

  task automatic test_half_read_waitreq();
    cpu_rd = 1'b1; cpu_addr = 32'h42; cpu_size = 2'b01; cpu_signed = 1'b0;
    avm_waitrequest = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) avm_waitrequest = 1'b0;
      #1;
      vec_cnt++;
      if ({avm_read, avm_write, avm_address, avm_byteenable, stall} !== {2'b10, 32'h40, 4'b1100, 1'b1}) begin
        err_cnt++;
        $display("[TB] FAIL hr_hold%0d got=%b%b/%h/%b/%b exp=10/00000040/1100/1", k, avm_read, avm_write, avm_address, avm_byteenable, stall);
      end
      step();
    end
    vec_cnt++; if (avm_read !== 1'b0) begin err_cnt++; $display("[TB] FAIL hr_rdwait_read got=%b exp=0", avm_read); end
    avm_readdatavalid = 1'b1; avm_readdata = 32'hABCD1234;
    step();
    avm_readdatavalid = 1'b0; avm_readdata = '0;
    exp_rdata = 32'h0000ABCD;
    #1;
    vec_cnt++; if (cpu_rdata !== exp_rdata) begin err_cnt++; $display("[TB] FAIL hr_rdata got=%h exp=%h", cpu_rdata, exp_rdata); end
    vec_cnt++; if ({rsp_valid, rsp_err} !== 2'b10) begin err_cnt++; $display("[TB] FAIL hr_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    drop_request();
    step();
  endtask

  task automatic test_misaligned();
    cpu_rd = 1'b1; cpu_addr = 32'h105; cpu_size = 2'b10; cpu_signed = 1'b0;
    #1;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("[TB] FAIL ma_stall_req got=%b exp=1", stall); end
    step();
    vec_cnt++; if ({avm_read, avm_write} !== 2'b00) begin err_cnt++; $display("[TB] FAIL ma_no_bus got=%b exp=00", {avm_read, avm_write}); end
    vec_cnt++; if ({stall, rsp_valid, rsp_err} !== 3'b011) begin err_cnt++; $display("[TB] FAIL ma_done got=%b exp=011", {stall, rsp_valid, rsp_err}); end
    vec_cnt++; if (cpu_rdata !== exp_rdata) begin err_cnt++; $display("[TB] FAIL ma_rdata got=%h exp=%h", cpu_rdata, exp_rdata); end
    drop_request();
    step();
    vec_cnt++; if ({rsp_valid, rsp_err} !== 2'b00) begin err_cnt++; $display("[TB] FAIL ma_idle got=%b exp=00", {rsp_valid, rsp_err}); end
    // misaligned half store: also no bus cycle, error completion
    cpu_wr = 1'b1; cpu_addr = 32'h301; cpu_size = 2'b01;
    step();
    vec_cnt++; if ({avm_write, rsp_valid, rsp_err} !== 3'b011) begin err_cnt++; $display("[TB] FAIL ma_half_wr got=%b exp=011", {avm_write, rsp_valid, rsp_err}); end
    drop_request();
    step();
  endtask

  task automatic test_back_to_back();
    // byte store to lane 1
    cpu_wr = 1'b1; cpu_addr = 32'h301; cpu_size = 2'b00; cpu_wdata = 32'h123456AB;
    step();
    vec_cnt++; if ({avm_address, avm_byteenable, avm_writedata} !== {32'h300, 4'b0010, 32'hABABABAB}) begin err_cnt++; $display("[TB] FAIL bb_byte_wr got=%h/%b/%h exp=00000300/0010/abababab", avm_address, avm_byteenable, avm_writedata); end
    step();
    // next request already present in DONE: stall must stay low there
    cpu_addr = 32'h302; cpu_size = 2'b01; cpu_wdata = 32'hFFFF1234;
    #1;
    vec_cnt++; if ({stall, rsp_valid} !== 2'b01) begin err_cnt++; $display("[TB] FAIL bb_done_ignore got=%b exp=01", {stall, rsp_valid}); end
    step();
    vec_cnt++; if ({stall, avm_write} !== 2'b10) begin err_cnt++; $display("[TB] FAIL bb_idle_req got=%b exp=10", {stall, avm_write}); end
    step();
    vec_cnt++; if ({avm_write, avm_address, avm_byteenable, avm_writedata} !== {1'b1, 32'h300, 4'b1100, 32'h12341234}) begin err_cnt++; $display("[TB] FAIL bb_half_wr got=%b/%h/%b/%h exp=1/00000300/1100/12341234", avm_write, avm_address, avm_byteenable, avm_writedata); end
    step();
    drop_request();
    step();
    // rd and wr together, size 11: read wins as a word, data valid on accept
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h8; cpu_size = 2'b11; cpu_wdata = 32'h11111111;
    step();
    vec_cnt++; if ({avm_read, avm_write, avm_byteenable} !== {2'b10, 4'b1111}) begin err_cnt++; $display("[TB] FAIL bb_rd_wins got=%b%b/%b exp=10/1111", avm_read, avm_write, avm_byteenable); end
    avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFEF00D;
    step();
    avm_readdatavalid = 1'b0; avm_readdata = '0;
    exp_rdata = 32'hCAFEF00D;
    #1;
    vec_cnt++; if ({rsp_valid, cpu_rdata} !== {1'b1, exp_rdata}) begin err_cnt++; $display("[TB] FAIL bb_fast_rd got=%b/%h exp=1/%h", rsp_valid, cpu_rdata, exp_rdata); end
    drop_request();
    step();
    // signed half load at offset 2, data returned with acceptance
    cpu_rd = 1'b1; cpu_addr = 32'h2; cpu_size = 2'b01; cpu_signed = 1'b1;
    step();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h80017FFF;
    step();
    avm_readdatavalid = 1'b0; avm_readdata = '0;
    exp_rdata = 32'hFFFF8001;
    #1;
    vec_cnt++; if ({rsp_valid, cpu_rdata} !== {1'b1, exp_rdata}) begin err_cnt++; $display("[TB] FAIL bb_sh_rd got=%b/%h exp=1/%h", rsp_valid, cpu_rdata, exp_rdata); end
    drop_request();
    step();
  endtask

  task automatic test_timeout();
    cpu_rd = 1'b1; cpu_addr = 32'h20; cpu_size = 2'b10; cpu_signed = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("[TB] FAIL to_wait%0d got=%b exp=1", i, stall); end
    end
    step();
`ifdef MEM_STALL_BRIDGE_TIMEOUT_EN
    vec_cnt++; if ({stall, rsp_valid, rsp_err, avm_read} !== 4'b0110) begin err_cnt++; $display("[TB] FAIL to_done got=%b exp=0110", {stall, rsp_valid, rsp_err, avm_read}); end
    vec_cnt++; if (cpu_rdata !== exp_rdata) begin err_cnt++; $display("[TB] FAIL to_rdata got=%h exp=%h", cpu_rdata, exp_rdata); end
    drop_request();
    step();
`else
    vec_cnt++; if ({stall, rsp_valid} !== 2'b10) begin err_cnt++; $display("[TB] FAIL to_still_wait got=%b exp=10", {stall, rsp_valid}); end
    avm_readdatavalid = 1'b1; avm_readdata = 32'h00000055;
    step();
    avm_readdatavalid = 1'b0; avm_readdata = '0;
    exp_rdata = 32'h00000055;
    #1;
    vec_cnt++; if ({rsp_valid, rsp_err, cpu_rdata} !== {2'b10, exp_rdata}) begin err_cnt++; $display("[TB] FAIL to_late_rd got=%b%b/%h exp=10/%h", rsp_valid, rsp_err, cpu_rdata, exp_rdata); end
    drop_request();
    step();
`endif
  endtask

  task automatic test_reset_midflight();
    cpu_rd = 1'b1; cpu_addr = 32'h10; cpu_size = 2'b10; cpu_signed = 1'b0;
    step();
    step();
    vec_cnt++; if ({stall, avm_read} !== 2'b10) begin err_cnt++; $display("[TB] FAIL rm_in_rdwait got=%b exp=10", {stall, avm_read}); end
    rst_n = 1'b0;
    drop_request();
    #1;
    vec_cnt++; if ({stall, avm_read, rsp_valid} !== 3'b000) begin err_cnt++; $display("[TB] FAIL rm_async got=%b exp=000", {stall, avm_read, rsp_valid}); end
    vec_cnt++; if (cpu_rdata !== 32'h0) begin err_cnt++; $display("[TB] FAIL rm_rdata_clr got=%h exp=0", cpu_rdata); end
    step();
    rst_n = 1'b1;
    step();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h12345678;
    step();
    avm_readdatavalid = 1'b0; avm_readdata = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vec_cnt++; if ({stall, rsp_valid, cpu_rdata} !== 34'h0) begin err_cnt++; $display("[TB] FAIL rm_late_rdv%0d got=%b%b/%h exp=00/0", i, stall, rsp_valid, cpu_rdata); end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_rdata = 32'h0;
    test_reset();
    test_word_write();
    test_signed_byte_read();
    test_half_read_waitreq();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
